// File: rtl/instr_fetch_unit.sv
`default_nettype none
// =============================================================================
// Module   : instr_fetch_unit
// Brief    : Fetch front-end: owns the fetch PC, issues credit-limited word
//            requests, buffers in-order responses with their PCs and flushes
//            on redirect. Optional macro FETCH_PERF_EN adds perf counters.
// Revision : 1.0
// =============================================================================
module instr_fetch_unit #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic        imem_req_valid_o,
    input  logic        imem_req_ready_i,
    output logic [31:0] imem_req_addr_o,
    input  logic        imem_rsp_valid_i,
    input  logic [31:0] imem_rsp_data_i,
    input  logic        redirect_valid_i,
    input  logic [31:0] redirect_pc_i,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    output logic [31:0] pc_plus4_o
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_fetched_o,
    output logic [31:0] perf_discard_o
`endif
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_CW = c_AW + 1;

    logic [31:0]     r_fetch_pc;
    logic [31:0]     r_rsp_pc;
    logic [c_CW-1:0] r_live;
    logic [c_CW-1:0] r_stale;
    logic [c_CW-1:0] r_occ;
    logic [c_AW-1:0] r_wr_ptr;
    logic [c_AW-1:0] r_rd_ptr;
    logic [31:0]     r_buf_data [DEPTH];
    logic [31:0]     r_buf_pc   [DEPTH];

    logic            w_req_fire;
    logic            w_pop;
    logic            w_discard;
    logic            w_keep;
    logic            w_push;
    logic            w_rsp_drop;
    logic [c_CW-1:0] w_redir_stale;
    logic [c_CW-1:0] w_occ_after_pop;

    // live + stale + occ never exceeds DEPTH, so the sum fits the counter width.
    assign imem_req_valid_o = !rst_i && !redirect_valid_i
                              && ((r_live + r_stale + r_occ) < c_CW'(DEPTH));
    assign imem_req_addr_o  = r_fetch_pc;

    assign w_req_fire = imem_req_valid_o && imem_req_ready_i;
    assign w_pop      = instr_valid_o && instr_ready_i;
    assign w_discard  = imem_rsp_valid_i && (r_stale != '0);
    assign w_keep     = imem_rsp_valid_i && (r_stale == '0) && (r_live != '0);
    assign w_push     = w_keep && !redirect_valid_i && !rst_i;

    // On redirect every owed response becomes stale, minus one arriving now.
    assign w_rsp_drop      = imem_rsp_valid_i && ((r_stale != '0) || (r_live != '0));
    assign w_redir_stale   = r_stale + r_live - c_CW'(w_rsp_drop);
    assign w_occ_after_pop = r_occ - c_CW'(w_pop);

    assign instr_valid_o = (r_occ != '0);
    assign instr_o       = instr_valid_o ? r_buf_data[r_rd_ptr] : 32'h0;
    assign pc_o          = instr_valid_o ? r_buf_pc[r_rd_ptr]   : 32'h0;
    assign pc_plus4_o    = pc_o + 32'd4;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_fetch_pc <= RESET_PC;
            r_rsp_pc   <= RESET_PC;
            r_live     <= '0;
            r_stale    <= '0;
            r_occ      <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
        end else if (redirect_valid_i) begin
            r_fetch_pc <= redirect_pc_i;
            r_rsp_pc   <= redirect_pc_i;
            r_live     <= '0;
            r_stale    <= w_redir_stale;
            r_occ      <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
        end else begin
            if (w_req_fire) begin
                r_fetch_pc <= r_fetch_pc + 32'd4;
            end
            if (w_push) begin
                r_rsp_pc <= r_rsp_pc + 32'd4;
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_live  <= r_live + c_CW'(w_req_fire) - c_CW'(w_keep);
            r_stale <= r_stale - c_CW'(w_discard);
            r_occ   <= r_occ + c_CW'(w_push) - c_CW'(w_pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_buf_data[r_wr_ptr] <= imem_rsp_data_i;
            r_buf_pc[r_wr_ptr]   <= r_rsp_pc;
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] r_perf_fetched;
    logic [31:0] r_perf_discard;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_perf_fetched <= '0;
            r_perf_discard <= '0;
        end else begin
            if (w_pop) begin
                r_perf_fetched <= r_perf_fetched + 32'd1;
            end
            // A redirect throws away the buffered words left after any pop.
            if (redirect_valid_i) begin
                r_perf_discard <= r_perf_discard + 32'(w_occ_after_pop) + 32'(w_rsp_drop);
            end else if (w_discard) begin
                r_perf_discard <= r_perf_discard + 32'd1;
            end
        end
    end

    assign perf_fetched_o = r_perf_fetched;
    assign perf_discard_o = r_perf_discard;
`else
    logic w_unused;
    assign w_unused = &{1'b0, w_occ_after_pop};
`endif

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// =============================================================================
// Module   : tb_instr_fetch_unit
// Brief    : Randomised bench for instr_fetch_unit with an in-order memory
//            model and a queue-based reference of in-flight and buffered words.
// Revision : 1.0
// =============================================================================
module tb_instr_fetch_unit;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid_o;
    logic        imem_req_ready_i;
    logic [31:0] imem_req_addr_o;
    logic        imem_rsp_valid_i;
    logic [31:0] imem_rsp_data_i;
    logic        redirect_valid_i;
    logic [31:0] redirect_pc_i;
    logic        instr_valid_o;
    logic        instr_ready_i;
    logic [31:0] instr_o;
    logic [31:0] pc_o;
    logic [31:0] pc_plus4_o;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched_o;
    logic [31:0] perf_discard_o;
`endif

    always #5 clk = ~clk;

    instr_fetch_unit #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .imem_req_valid_o (imem_req_valid_o),
        .imem_req_ready_i (imem_req_ready_i),
        .imem_req_addr_o  (imem_req_addr_o),
        .imem_rsp_valid_i (imem_rsp_valid_i),
        .imem_rsp_data_i  (imem_rsp_data_i),
        .redirect_valid_i (redirect_valid_i),
        .redirect_pc_i    (redirect_pc_i),
        .instr_valid_o    (instr_valid_o),
        .instr_ready_i    (instr_ready_i),
        .instr_o          (instr_o),
        .pc_o             (pc_o),
        .pc_plus4_o       (pc_plus4_o)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched_o   (perf_fetched_o),
        .perf_discard_o   (perf_discard_o)
`endif
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    // memory: accepted requests with the cycle their response is due
    typedef struct {logic [31:0] addr; int due;} mreq_t;
    mreq_t mq[$];
    int    last_due = 0;
    int    lat_min  = 1;
    int    lat_max  = 1;
    int    rdy_mode = 0;
    bit    spur_en  = 0;

    // reference: in-flight requests (keep flag) and buffered words
    typedef struct {logic [31:0] pc; bit keep;} inf_t;
    typedef struct {logic [31:0] w; logic [31:0] pc;} ent_t;
    inf_t        infl[$];
    ent_t        fq[$];
    logic [31:0] m_fetch_pc = RESET_PC;
`ifdef FETCH_PERF_EN
    logic [31:0] m_fetched = 0;
    logic [31:0] m_discard = 0;
`endif

    // observations taken from the DUT pins
    logic [31:0] req_log[$];
    logic [31:0] del_log[$];
    logic [31:0] del_ilog[$];
    int          first_req_cyc;
    int          first_val_cyc;
    logic        s_ivalid;

    function automatic logic [31:0] memw(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic clear_logs();
        req_log.delete();
        del_log.delete();
        del_ilog.delete();
        first_req_cyc = -1;
        first_val_cyc = -1;
    endtask

    // One clock: drive inputs, compare outputs against the reference, advance it.
    task automatic step(input bit rs, input bit rd, input logic [31:0] rpc, input bit crdy);
        bit          mrdy;
        bit          rv;
        bit          real_rsp;
        bit          exp_rv;
        bit          pop;
        bit          fire;
        logic [31:0] rdata;
        inf_t        h;
        int          due;
        @(negedge clk);
        case (rdy_mode)
            0:       mrdy = 1'b1;
            1:       mrdy = (cyc % 2 == 0);
            default: mrdy = ($urandom_range(0, 1) == 1);
        endcase
        rv       = 1'b0;
        real_rsp = 1'b0;
        rdata    = $urandom;
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            rv       = 1'b1;
            real_rsp = 1'b1;
            rdata    = memw(mq[0].addr);
        end else if (spur_en && mq.size() == 0 && $urandom_range(0, 15) == 0) begin
            rv = 1'b1;
        end
        rst              = rs;
        imem_req_ready_i = mrdy;
        imem_rsp_valid_i = rv;
        imem_rsp_data_i  = rdata;
        redirect_valid_i = rd;
        redirect_pc_i    = rpc;
        instr_ready_i    = crdy;
        #1;
        exp_rv = !rs && !rd && (infl.size() + fq.size() < DEPTH);
        chk("req_valid", imem_req_valid_o, exp_rv);
        if (exp_rv) chk("req_addr", imem_req_addr_o, m_fetch_pc);
        if (!rs) begin
            chk("instr_valid", instr_valid_o, fq.size() != 0);
            if (fq.size() != 0) begin
                chk("instr", instr_o, fq[0].w);
                chk("pc", pc_o, fq[0].pc);
                chk("pc_plus4", pc_plus4_o, fq[0].pc + 32'd4);
            end
`ifdef FETCH_PERF_EN
            chk("perf_fetched", perf_fetched_o, m_fetched);
            chk("perf_discard", perf_discard_o, m_discard);
`endif
        end
        s_ivalid = instr_valid_o;
        if (imem_req_valid_o && mrdy) begin
            req_log.push_back(imem_req_addr_o);
            if (first_req_cyc < 0) first_req_cyc = cyc;
        end
        if (instr_valid_o && first_val_cyc < 0) first_val_cyc = cyc;
        if (instr_valid_o && crdy && !rs) begin
            del_log.push_back(pc_o);
            del_ilog.push_back(instr_o);
        end

        pop  = !rs && fq.size() != 0 && crdy;
        fire = exp_rv && mrdy;
        if (rs) begin
            infl.delete();
            fq.delete();
            mq.delete();
            m_fetch_pc = RESET_PC;
`ifdef FETCH_PERF_EN
            m_fetched = 0;
            m_discard = 0;
`endif
        end else begin
            if (pop) begin
                void'(fq.pop_front());
`ifdef FETCH_PERF_EN
                m_fetched++;
`endif
            end
            if (real_rsp) void'(mq.pop_front());
            if (rv && infl.size() > 0) begin
                h = infl.pop_front();
                if (h.keep && !rd) fq.push_back('{memw(h.pc), h.pc});
`ifdef FETCH_PERF_EN
                else m_discard++;
`endif
            end
            if (rd) begin
`ifdef FETCH_PERF_EN
                m_discard += fq.size();
`endif
                fq.delete();
                foreach (infl[i]) infl[i].keep = 1'b0;
                m_fetch_pc = rpc;
            end else if (fire) begin
                infl.push_back('{m_fetch_pc, 1'b1});
                due = cyc + $urandom_range(lat_min, lat_max);
                if (due <= last_due) due = last_due + 1;
                mq.push_back('{imem_req_addr_o, due});
                last_due   = due;
                m_fetch_pc = m_fetch_pc + 32'd4;
            end
        end
        cyc++;
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 32'h0, 1'b1);
        step(1'b1, 1'b0, 32'h0, 1'b1);
        clear_logs();
    endtask

    task automatic chk_reset_outs();
        @(negedge clk);
        #1;
        chk("rst_req_valid", imem_req_valid_o, 1'b0);
        chk("rst_req_addr", imem_req_addr_o, RESET_PC);
        chk("rst_instr_valid", instr_valid_o, 1'b0);
        chk("rst_instr", instr_o, 32'h0);
        chk("rst_pc", pc_o, 32'h0);
        chk("rst_pc_plus4", pc_plus4_o, 32'h4);
`ifdef FETCH_PERF_EN
        chk("rst_perf_fetched", perf_fetched_o, 32'h0);
        chk("rst_perf_discard", perf_discard_o, 32'h0);
`endif
    endtask

    initial begin
        int          mark;
        logic [31:0] r;
        rst = 1'b1; imem_req_ready_i = 1'b0; imem_rsp_valid_i = 1'b0;
        imem_rsp_data_i = 32'h0; redirect_valid_i = 1'b0; redirect_pc_i = 32'h0;
        instr_ready_i = 1'b0;
        clear_logs();

        // streaming at latency 1
        do_reset();
        chk_reset_outs();
        clear_logs();
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 32'h0, 1'b1);
        chk("first_req_addr", req_log.size() > 0 ? req_log[0] : 32'hDEAD_BEEF, 32'h0);
        chk("first_valid_lat", first_val_cyc - first_req_cyc, 32'd2);
        chk("stream_pc0", del_log.size() > 2 ? del_log[0] : 32'hDEAD_BEEF, 32'h0);
        chk("stream_pc1", del_log.size() > 2 ? del_log[1] : 32'hDEAD_BEEF, 32'h4);
        chk("stream_pc2", del_log.size() > 2 ? del_log[2] : 32'hDEAD_BEEF, 32'h8);
        chk("stream_word2", del_ilog.size() > 2 ? del_ilog[2] : 32'hDEAD_BEEF, memw(32'h8));

        // consumer stalled: credit stops issue at DEPTH
        do_reset();
        for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 32'h0, 1'b0);
        chk("stall_req_count", req_log.size(), 32'd4);
        chk("stall_head_pc", pc_o, 32'h0);
        for (int i = 0; i < 30 && req_log.size() < 5; i++) step(1'b0, 1'b0, 32'h0, 1'b1);
        chk("resume_addr", req_log.size() >= 5 ? req_log[4] : 32'hDEAD_BEEF, 32'h10);

        // latency 3, redirect with three requests outstanding
        do_reset();
        lat_min = 3; lat_max = 3;
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'h0, 1'b1);
        step(1'b0, 1'b1, 32'h100, 1'b1);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        chk("flush_empty", s_ivalid, 1'b0);
        mark = del_log.size();
        for (int i = 0; i < 40 && del_log.size() == mark; i++) step(1'b0, 1'b0, 32'h0, 1'b1);
        chk("redir_pc", del_log.size() > mark ? del_log[mark] : 32'hDEAD_BEEF, 32'h100);
        chk("redir_word", del_ilog.size() > mark ? del_ilog[mark] : 32'hDEAD_BEEF, memw(32'h100));

        // redirect coinciding with head transfer of 0x8 and a response
        do_reset();
        lat_min = 2; lat_max = 2;
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 32'h0, 1'b1);
        step(1'b0, 1'b1, 32'h200, 1'b1);
        chk("same_cycle_xfer", del_log.size() > 0 ? del_log[del_log.size()-1] : 32'hDEAD_BEEF, 32'h8);
        mark = del_log.size();
        req_log.delete();
        for (int i = 0; i < 40 && del_log.size() == mark; i++) step(1'b0, 1'b0, 32'h0, 1'b1);
        chk("restart_addr", req_log.size() > 0 ? req_log[0] : 32'hDEAD_BEEF, 32'h200);
        chk("restart_pc", del_log.size() > mark ? del_log[mark] : 32'hDEAD_BEEF, 32'h200);

        // reset mid-stream with requests outstanding
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'h0, 1'b1);
        step(1'b1, 1'b0, 32'h0, 1'b1);
        chk_reset_outs();
        clear_logs();
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'h0, 1'b1);
        chk("post_rst_addr", req_log.size() > 0 ? req_log[0] : 32'hDEAD_BEEF, RESET_PC);

        // random: toggling memory ready, latency 1..4, random redirects
        do_reset();
        rdy_mode = 1; lat_min = 1; lat_max = 4; spur_en = 1'b1;
        for (int i = 0; i < 6000 && del_log.size() < 200; i++) begin
            if ($urandom_range(0, 29) == 0) begin
                r = $urandom;
                if ($urandom_range(0, 3) == 0) r = 32'hFFFF_FFF0;
                step(1'b0, 1'b1, r & 32'hFFFF_FFFC, $urandom_range(0, 3) != 0);
            end else begin
                step(1'b0, 1'b0, 32'h0, $urandom_range(0, 3) != 0);
            end
        end
        chk("random_delivered", del_log.size() >= 200, 1'b1);

        rdy_mode = 2;
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 99) == 0, $urandom_range(0, 24) == 0,
                 $urandom & 32'hFFFF_FFFC, $urandom_range(0, 1) == 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
